// File: rtl/prog_loader.sv
// prog_loader
//   Program RAM owner and stream loader for the single-cycle core. A program
//   arrives as a framed byte stream (length, payload, checksum) on a
//   valid/ready link. The core is held in reset until a frame has been
//   received and its checksum verified. Instructions are served
//   combinationally from the RAM so the core fetch path is unchanged.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   ld_start     one-cycle pulse: begin or restart a load
//   ld_valid     stream byte valid
//   ld_data      stream byte
//   ld_ready     loader accepts a byte this cycle (LEN/DATA/CSUM)
//   pc           core program counter
//   instruction  mem[pc] when loaded and pc < prog_len, else 0
//   core_reset   registered reset to the core, low only in RUN
//   loaded       program verified, core running
//   err          last load failed
//   prog_len     length of the last verified program (0..DEPTH)
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | nothing loaded since reset
// LEN   | waiting for the length byte
// DATA  | receiving payload bytes into the RAM
// CSUM  | waiting for the checksum byte
// RUN   | program verified, core released
// ERR   | frame rejected, core held in reset

module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    output logic              core_reset,
    output logic              loaded,
    output logic              err,
    output logic [ADDR_W:0]   prog_len
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic len_ok;
    logic last_byte;

    assign ld_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign accept    = ld_valid && ld_ready;
    assign len_ok    = (32'(ld_data) >= 32'd1) && (32'(ld_data) <= DEPTH_U);
    assign last_byte = (idx == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            core_reset <= 1'b1;
            loaded     <= 1'b0;
            err        <= 1'b0;
            prog_len   <= '0;
            len_q      <= '0;
            idx        <= '0;
            sum        <= '0;
        end else if (ld_start) begin
            // restart wins over any byte presented in the same cycle
            state      <= S_LEN;
            core_reset <= 1'b1;
            loaded     <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_LEN: begin
                    if (accept) begin
                        if (len_ok) begin
                            len_q <= LEN_W'(ld_data);
                            idx   <= '0;
                            sum   <= '0;
                            state <= S_DATA;
                        end else begin
                            err        <= 1'b1;
                            core_reset <= 1'b1;
                            loaded     <= 1'b0;
                            state      <= S_ERR;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        sum <= sum + ld_data;
                        idx <= idx + LEN_W'(1);
                        if (last_byte) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (ld_data == sum) begin
                            prog_len   <= len_q;
                            core_reset <= 1'b0;
                            loaded     <= 1'b1;
                            state      <= S_RUN;
                        end else begin
                            err        <= 1'b1;
                            core_reset <= 1'b1;
                            loaded     <= 1'b0;
                            state      <= S_ERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is not reset; only payload bytes that are actually consumed write it
    always_ff @(posedge clk) begin
        if (!reset && !ld_start && (state == S_DATA) && accept) begin
            mem[idx[ADDR_W-1:0]] <= ld_data;
        end
    end

    always_comb begin
        instruction = '0;
        if (loaded && ({1'b0, pc} < prog_len)) begin
            instruction = mem[pc];
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [4:0] pc;
    logic [7:0] instruction;
    logic       core_reset;
    logic       loaded;
    logic       err;
    logic [5:0] prog_len;

    prog_loader dut (
        .clk         (clk),
        .reset       (reset),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .pc          (pc),
        .instruction (instruction),
        .core_reset  (core_reset),
        .loaded      (loaded),
        .err         (err),
        .prog_len    (prog_len)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] model_mem [32];
    int         model_len;
    logic       model_loaded;
    logic [7:0] fr [$];

    typedef struct {
        logic       s;
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       l;
        logic       cr;
        logic       e;
        logic [5:0] len;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge, outputs are read there too
    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        ld_start = s;
        ld_valid = v;
        ld_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic l, input logic cr,
                               input logic e, input logic [5:0] len);
        check({tag, ".loaded"},     32'(loaded),     32'(l));
        check({tag, ".core_reset"}, 32'(core_reset), 32'(cr));
        check({tag, ".err"},        32'(err),        32'(e));
        check({tag, ".prog_len"},   32'(prog_len),   32'(len));
    endtask

    task automatic check_fetch(input string tag);
        logic [7:0] exp;
        for (int p = 0; p < 32; p++) begin
            pc = 5'(p);
            #1;
            exp = (model_loaded && p < model_len) ? model_mem[p] : 8'h00;
            check($sformatf("%s.instr[%0d]", tag, p), 32'(instruction), 32'(exp));
        end
        pc = 5'd0;
    endtask

    task automatic start(input string tag);
        cyc(1'b1, 1'b0, 8'h00);
        model_loaded = 1'b0;
        check({tag, ".start_ready"},  32'(ld_ready),   32'd1);
        check({tag, ".start_cr"},     32'(core_reset), 32'd1);
        check({tag, ".start_loaded"}, 32'(loaded),     32'd0);
        check({tag, ".start_err"},    32'(err),        32'd0);
    endtask

    // gaps idle cycles with valid low (and junk data) between bytes
    task automatic send(input string tag, input logic [7:0] q [$], input int gaps);
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("%s.ready[%0d]", tag, i), 32'(ld_ready), 32'd1);
            cyc(1'b0, 1'b1, q[i]);
            if (i != q.size() - 1) begin
                for (int g = 0; g < gaps; g++) begin
                    check($sformatf("%s.gap_ready[%0d]", tag, i), 32'(ld_ready), 32'd1);
                    cyc(1'b0, 1'b0, 8'hEE);
                end
            end
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] s;

        reset    = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        pc       = 5'd0;
        model_loaded = 1'b0;
        model_len    = 0;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(ld_ready), 32'd0);
        check_flags("rst", 1'b0, 1'b1, 1'b0, 6'd0);
        check("rst.instr", 32'(instruction), 32'd0);
        reset = 1'b0;

        // A1+22+3F = 0x102, so the checksum byte is 02
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[1] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[2] = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[3] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[4] = '{1'b0, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[5] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 6'd3};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3};
        for (int i = 0; i < 7; i++) begin
            check($sformatf("vec%0d.ready", i), 32'(ld_ready), 32'(vecs[i].rdy));
            cyc(vecs[i].s, vecs[i].v, vecs[i].d);
            check_flags($sformatf("vec%0d", i), vecs[i].l, vecs[i].cr, vecs[i].e, vecs[i].len);
        end
        model_mem[0] = 8'hA1; model_mem[1] = 8'h22; model_mem[2] = 8'h3F;
        model_len = 3; model_loaded = 1'b1;
        check_fetch("basic");

        // restart from RUN: core_reset rises, loaded clears, fetch returns 0
        start("run_restart");
        check("run_restart.instr0", 32'(instruction), 32'd0);

        // bad checksum (10+20 = 30, 31 sent)
        fr = {8'h02, 8'h10, 8'h20, 8'h31};
        send("badsum", fr, 0);
        check_flags("badsum", 1'b0, 1'b1, 1'b1, 6'd3);
        check("badsum.ready", 32'(ld_ready), 32'd0);
        check_fetch("badsum");

        // 04 is not the modulo-256 sum of A1,22,3F
        start("sum04");
        fr = {8'h03, 8'hA1, 8'h22, 8'h3F, 8'h04};
        send("sum04", fr, 0);
        check_flags("sum04", 1'b0, 1'b1, 1'b1, 6'd3);

        start("len00");
        fr = {8'h00};
        send("len00", fr, 0);
        check_flags("len00", 1'b0, 1'b1, 1'b1, 6'd3);
        check("len00.ready", 32'(ld_ready), 32'd0);

        start("len21");
        fr = {8'h21};
        send("len21", fr, 0);
        check_flags("len21", 1'b0, 1'b1, 1'b1, 6'd3);
        check("len21.ready", 32'(ld_ready), 32'd0);

        // full-depth program
        start("len20");
        fr = {8'h20};
        s = 8'h00;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 13 + 5);
            fr.push_back(b);
            model_mem[i] = b;
            s = s + b;
        end
        fr.push_back(s);
        send("len20", fr, 0);
        check_flags("len20", 1'b1, 1'b0, 1'b0, 6'd32);
        model_len = 32; model_loaded = 1'b1;
        check_fetch("len20");

        // same basic frame with two idle cycles between bytes
        start("gaps");
        fr = {8'h03, 8'hA1, 8'h22, 8'h3F, 8'h02};
        send("gaps", fr, 2);
        check_flags("gaps", 1'b1, 1'b0, 1'b0, 6'd3);
        model_mem[0] = 8'hA1; model_mem[1] = 8'h22; model_mem[2] = 8'h3F;
        model_len = 3; model_loaded = 1'b1;
        check_fetch("gaps");

        // restart after two payload bytes; the byte beside ld_start is dropped
        start("midload");
        fr = {8'h04, 8'h11, 8'h22};
        send("midload", fr, 0);
        cyc(1'b1, 1'b1, 8'h55);
        check("midload.restart_ready", 32'(ld_ready), 32'd1);
        check_flags("midload.restart", 1'b0, 1'b1, 1'b0, 6'd3);
        fr = {8'h02, 8'h5A, 8'h66, 8'hC0};
        send("midload2", fr, 0);
        check_flags("midload2", 1'b1, 1'b0, 1'b0, 6'd2);
        model_mem[0] = 8'h5A; model_mem[1] = 8'h66;
        model_len = 2; model_loaded = 1'b1;
        check_fetch("midload2");

        // reset during DATA
        start("rstmid");
        fr = {8'h03, 8'hA1};
        send("rstmid", fr, 0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'h77);
        reset = 1'b0;
        ld_valid = 1'b0;
        check("rstmid.ready", 32'(ld_ready), 32'd0);
        check_flags("rstmid", 1'b0, 1'b1, 1'b0, 6'd0);
        model_loaded = 1'b0;
        check_fetch("rstmid");
        cyc(1'b0, 1'b0, 8'h00);
        check("rstmid.idle_ready", 32'(ld_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
